// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: runs one WRITE/READ/MOVE request at a time on the A/B/C register-file bus and returns one response per request.
// rsp_valid comes 2/3/4/1 cycles after acceptance (WRITE/READ/MOVE/illegal); while rsp_ready is low the response is held and no request is taken.
module reg_xfer_ctrl #(
  parameter int WORD_SIZE = 19
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [1:0]           req_src,
  input  logic [1:0]           req_dst,
  input  logic [WORD_SIZE-1:0] req_imm,
  output logic                 LOAD_REG,
  output logic [1:0]           LOAD_SELECT,
  output logic [WORD_SIZE-1:0] reg_wdata,
  input  logic [WORD_SIZE-1:0] reg_rdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_MOVE  = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RWAIT,
    MVWR,
    RESP
  } state_t;

  // src is consumed at acceptance, so only op/dst/imm live past it
  typedef struct packed {
    logic [1:0]           op;
    logic [1:0]           dst;
    logic [WORD_SIZE-1:0] imm;
  } req_t;

  state_t               state_q, state_d;
  req_t                 req_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 accept;
  logic                 req_legal;

  logic                 load_reg_d;
  logic [1:0]           load_sel_d;
  logic [WORD_SIZE-1:0] wdata_d;
  logic [WORD_SIZE-1:0] rsp_data_d;
  logic                 rsp_err_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_legal = 1'b0;
    case (req_op)
      OP_WRITE: req_legal = (req_dst != SEL_NONE);
      OP_READ:  req_legal = (req_src != SEL_NONE);
      OP_MOVE:  req_legal = (req_src != SEL_NONE) && (req_dst != SEL_NONE);
      default:  req_legal = 1'b0;
    endcase
  end

  // Bus outputs are produced together with the next state so they register on the same edge.
  always_comb begin
    state_d    = state_q;
    load_reg_d = 1'b0;
    load_sel_d = SEL_NONE;
    wdata_d    = '0;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!req_legal) begin
            state_d    = RESP;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
          end else if (req_op == OP_WRITE) begin
            state_d    = WR;
            load_reg_d = 1'b1;
            load_sel_d = req_dst;
            wdata_d    = req_imm;
          end else begin
            state_d    = RD;
            load_sel_d = req_src;
          end
        end
      end
      WR: begin
        state_d    = RESP;
        rsp_data_d = req_q.imm;
        rsp_err_d  = 1'b0;
      end
      RD: state_d = RWAIT;
      RWAIT: begin
        if (req_q.op == OP_MOVE) begin
          state_d    = MVWR;
          load_reg_d = 1'b1;
          load_sel_d = req_q.dst;
          wdata_d    = reg_rdata;
        end else begin
          state_d    = RESP;
          rsp_data_d = reg_rdata;
          rsp_err_d  = 1'b0;
        end
      end
      MVWR: begin
        state_d    = RESP;
        rsp_data_d = rdata_q;
        rsp_err_d  = 1'b0;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        req_q.op  <= req_op;
        req_q.dst <= req_dst;
        req_q.imm <= req_imm;
      end
      if (state_q == RWAIT) rdata_q <= reg_rdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      LOAD_REG    <= 1'b0;
      LOAD_SELECT <= SEL_NONE;
      reg_wdata   <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      LOAD_REG    <= load_reg_d;
      LOAD_SELECT <= load_sel_d;
      reg_wdata   <= wdata_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: directed cases plus random requests against a transaction-level register model.
module tb_reg_xfer_ctrl;
  localparam int W = 19;
  localparam logic [1:0] OP_WR = 2'b00, OP_RD = 2'b01, OP_MV = 2'b10, OP_BAD = 2'b11;
  localparam logic [1:0] RA = 2'd0, RB = 2'd1, RC = 2'd2, RX = 2'd3;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = '0, req_src = '0, req_dst = '0;
  logic [W-1:0] req_imm = '0;
  logic         LOAD_REG;
  logic [1:0]   LOAD_SELECT;
  logic [W-1:0] reg_wdata, reg_rdata;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         rsp_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // register file with a registered read port, as seen on the bus
  logic [W-1:0] rf [3] = '{default: '0};
  logic [W-1:0] rf_rdata = '0;
  // what the registers should hold after each completed transaction
  logic [W-1:0] gold [3] = '{default: '0};

  reg_xfer_ctrl #(.WORD_SIZE(W)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src(req_src), .req_dst(req_dst), .req_imm(req_imm),
    .LOAD_REG(LOAD_REG), .LOAD_SELECT(LOAD_SELECT), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 CLK = ~CLK;

  assign reg_rdata = rf_rdata;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (LOAD_SELECT != RX) begin
      if (LOAD_REG) rf[LOAD_SELECT] <= reg_wdata;
      else          rf_rdata <= rf[LOAD_SELECT];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] rnd2();
    logic [31:0] r;
    r = $urandom;
    return r[1:0];
  endfunction

  function automatic logic [W-1:0] rndw();
    logic [31:0] r;
    r = $urandom;
    return r[W-1:0];
  endfunction

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    req_valid = r[0];
    req_op    = rnd2();
    req_src   = rnd2();
    req_dst   = rnd2();
    req_imm   = rndw();
  endtask

  // Issue one request at a negedge in IDLE, check every cycle up to and after its response.
  task automatic do_req(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                        input logic [W-1:0] imm, input int stall, output int rsp_cyc);
    logic         legal, exp_err, exp_lr, wd_chk;
    int           lat;
    logic [1:0]   exp_sel;
    logic [W-1:0] exp_data, src_val, exp_wd;
    case (op)
      OP_WR:   legal = (dst != RX);
      OP_RD:   legal = (src != RX);
      OP_MV:   legal = (src != RX) && (dst != RX);
      default: legal = 1'b0;
    endcase
    src_val = (src != RX) ? gold[src] : '0;
    exp_err = !legal;
    if (!legal)           begin lat = 1; exp_data = '0;      end
    else if (op == OP_WR) begin lat = 2; exp_data = imm;     end
    else if (op == OP_RD) begin lat = 3; exp_data = src_val; end
    else                  begin lat = 4; exp_data = src_val; end
    rsp_cyc = -1;

    chk("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1; req_op = op; req_src = src; req_dst = dst; req_imm = imm;
    rsp_ready = (stall == 0);
    @(posedge CLK);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      scramble();
      exp_lr = 1'b0; exp_sel = RX; exp_wd = '0; wd_chk = 1'b0;
      if (legal && k == 1) begin
        exp_lr  = (op == OP_WR);
        exp_sel = (op == OP_WR) ? dst : src;
        exp_wd  = imm;
        wd_chk  = (op == OP_WR);
      end
      if (legal && op == OP_MV && k == 3) begin
        exp_lr = 1'b1; exp_sel = dst; exp_wd = src_val; wd_chk = 1'b1;
      end
      chk("load_reg", 32'(LOAD_REG), 32'(exp_lr));
      chk("load_select", 32'(LOAD_SELECT), 32'(exp_sel));
      if (wd_chk) chk("reg_wdata", 32'(reg_wdata), 32'(exp_wd));
      chk("req_ready_busy", 32'(req_ready), 0);
      chk("rsp_valid_timing", 32'(rsp_valid), 32'(k == lat));
      if (k == lat) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_data));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        rsp_cyc = cyc;
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      scramble();
      chk("stall_rsp_valid", 32'(rsp_valid), 1);
      chk("stall_rsp_data", 32'(rsp_data), 32'(exp_data));
      chk("stall_rsp_err", 32'(rsp_err), 32'(exp_err));
      chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_load_select", 32'(LOAD_SELECT), 32'(RX));
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 0);
    chk("post_req_ready", 32'(req_ready), 1);
    chk("post_load_select", 32'(LOAD_SELECT), 32'(RX));
    if (legal && op == OP_WR) gold[dst] = imm;
    if (legal && op == OP_MV) gold[dst] = src_val;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 1);
    chk({tag, "_load_reg"}, 32'(LOAD_REG), 0);
    chk({tag, "_load_select"}, 32'(LOAD_SELECT), 32'(RX));
    chk({tag, "_reg_wdata"}, 32'(reg_wdata), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
  endtask

  initial begin
    int rc1, rc2, rc3, rcx, stall;
    logic [31:0] r;

    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);

    do_req(OP_WR, RX, RB, 19'h5A5A5, 0, rcx);

    do_req(OP_WR, RB, RA, 19'h00123, 0, rcx);
    do_req(OP_MV, RA, RC, '0, 0, rcx);
    do_req(OP_RD, RC, RX, '0, 0, rcx);

    do_req(OP_BAD, RA, RA, 19'h00001, 0, rcx);
    do_req(OP_RD, RX, RA, '0, 0, rcx);
    do_req(OP_WR, RA, RX, 19'h3C3C3, 0, rcx);

    do_req(OP_RD, RB, RA, '0, 5, rcx);
    do_req(OP_WR, RX, RA, 19'h7FFFF, 0, rcx);

    // abort a MOVE B->C in its read-wait cycle; C must keep its value
    req_valid = 1'b1; req_op = OP_MV; req_src = RB; req_dst = RC; req_imm = '0;
    rsp_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("abort_read_select", 32'(LOAD_SELECT), 32'(RB));
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_reset_outputs("midmove");
    repeat (2) begin
      @(negedge CLK);
      chk("inrst_load_select", 32'(LOAD_SELECT), 32'(RX));
      chk("inrst_rsp_valid", 32'(rsp_valid), 0);
    end
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("postrst_load_select", 32'(LOAD_SELECT), 32'(RX));
      chk("postrst_rsp_valid", 32'(rsp_valid), 0);
    end
    do_req(OP_RD, RC, RA, '0, 0, rcx);

    do_req(OP_WR, RX, RA, 19'd1, 0, rc1);
    do_req(OP_WR, RX, RB, 19'd2, 0, rc2);
    do_req(OP_WR, RX, RC, 19'd3, 0, rc3);
    chk("stream_gap_ab", 32'(rc2 - rc1), 3);
    chk("stream_gap_bc", 32'(rc3 - rc2), 3);
    do_req(OP_RD, RA, RX, '0, 0, rcx);
    do_req(OP_RD, RB, RX, '0, 0, rcx);
    do_req(OP_RD, RC, RX, '0, 0, rcx);

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(3, 0);
      stall = (r == 0) ? int'($urandom_range(4, 1)) : 0;
      do_req(rnd2(), rnd2(), rnd2(), rndw(), stall, rcx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
